// File: rtl/spi_pkg.sv
// Shared types and command-byte field positions for the SPI register bank.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      RD_DATA = 2'd2,
      DISCARD = 2'd3
   } state_t;

   localparam int NUM_REGS = 16;
   localparam int RW_BIT   = 7;
   localparam int RSV_MSB  = 6;
   localparam int RSV_LSB  = 4;
   localparam int ADDR_MSB = 3;

   // A command byte is legal only when its reserved field is all zero.
   function automatic logic cmd_legal(input logic [7:0] cmd);
      return cmd[RSV_MSB:RSV_LSB] == '0;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by a registered edge detector.
// FALL selects which transition of the synchronised level produces the pulse.
module sync_edge #(
   parameter int STAGES = 2,
   parameter bit FALL   = 1'b0
) (
   input  logic clk27m,
   input  logic rst,
   input  logic sig,
   output logic pulse
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the async level through the chain and emit a one-cycle edge pulse.
   always_ff @(posedge clk27m or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], sig};
         prev_q <= sync_q[STAGES-1];
         pulse  <= FALL ? (~sync_q[STAGES-1] & prev_q) : (sync_q[STAGES-1] & ~prev_q);
      end
   end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: decodes command bytes from an SPI slave,
// writes registers 1..15, streams register reads back, register 0 is an ID.
//
// state   | meaning
// IDLE    | waiting for a command byte
// WR_DATA | each byte is written to reg[addr], addr auto-increments
// RD_DATA | each byte advances addr and loads reg[addr] for shifting out
// DISCARD | illegal command seen, ignore bytes until cs rises
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                  clk27m,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  data_valid,
   input  logic                  cs,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   output logic [8*NUM_REGS-1:0] regs,
   output logic                  wr_stb,
   output logic [3:0]            wr_addr,
   output logic                  frame_err
);

   logic       byte_raw;
   logic       end_raw;
   logic       byte_stb;
   logic       frame_end;
   logic [7:0] rx_q;
   state_t     state;
   state_t     state_nxt;
   logic [3:0] addr;
   logic [3:0] addr_nxt;
   logic       wr_en;
   logic       tx_load;
   logic [7:0] tx_val;
   logic       err;
   logic [7:0] mem [1:NUM_REGS-1];

   sync_edge #(.STAGES(SYNC_STAGES), .FALL(1'b0)) u_sync_dv (
      .clk27m (clk27m),
      .rst    (rst),
      .sig    (data_valid),
      .pulse  (byte_raw)
   );

   // cs is synchronised inverted so the reset value of the chain matches an
   // idle bus; a cs rise is then a fall of the synchronised select.
   sync_edge #(.STAGES(SYNC_STAGES), .FALL(1'b1)) u_sync_cs (
      .clk27m (clk27m),
      .rst    (rst),
      .sig    (~cs),
      .pulse  (end_raw)
   );

   // Capture the byte alongside its strobe; both event paths share this stage.
   always_ff @(posedge clk27m or posedge rst) begin
      if (rst) begin
         byte_stb  <= 1'b0;
         frame_end <= 1'b0;
         rx_q      <= '0;
      end else begin
         byte_stb  <= byte_raw;
         frame_end <= end_raw;
         if (byte_raw) rx_q <= rx_data;
      end
   end

   assign regs[7:0] = ID_VALUE;
   for (genvar k = 1; k < NUM_REGS; k++) begin : g_regs
      assign regs[8*k +: 8] = mem[k];
   end

   // Next-state and pulse decode; a byte arriving with frame_end is still acted on.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      wr_en     = 1'b0;
      tx_load   = 1'b0;
      tx_val    = tx_data;
      err       = 1'b0;
      if (byte_stb) begin
         case (state)
            IDLE: begin
               if (!cmd_legal(rx_q)) begin
                  err       = 1'b1;
                  state_nxt = DISCARD;
               end else begin
                  addr_nxt = rx_q[ADDR_MSB:0];
                  if (rx_q[RW_BIT]) begin
                     tx_load   = 1'b1;
                     tx_val    = regs[{rx_q[ADDR_MSB:0], 3'b000} +: 8];
                     state_nxt = RD_DATA;
                  end else begin
                     state_nxt = WR_DATA;
                  end
               end
            end
            WR_DATA: begin
               wr_en    = (addr != 4'd0);
               addr_nxt = addr + 4'd1;
            end
            RD_DATA: begin
               addr_nxt = addr + 4'd1;
               tx_load  = 1'b1;
               tx_val   = regs[{addr_nxt, 3'b000} +: 8];
            end
            DISCARD: begin
               state_nxt = DISCARD;
            end
            default: state_nxt = IDLE;
         endcase
      end
      if (frame_end) begin
         state_nxt = IDLE;
         addr_nxt  = 4'd0;
      end
   end

   // State, address pointer and registered output pulses.
   always_ff @(posedge clk27m or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= 4'd0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         wr_stb    <= 1'b0;
         wr_addr   <= 4'd0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         tx_data   <= tx_val;
         tx_start  <= tx_load;
         wr_stb    <= wr_en;
         frame_err <= err;
         if (wr_en) wr_addr <= addr;
      end
   end

   // Register storage for addresses 1..15.
   always_ff @(posedge clk27m or posedge rst) begin
      if (rst) begin
         for (int k = 1; k < NUM_REGS; k++) mem[k] <= '0;
      end else if (wr_en) begin
         mem[addr] <= rx_q;
      end
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: table of directed frames, hand-written
// latency and reset-abort sequences, then random frames against a frame-level model.
module tb_spi_reg_bank;

   localparam logic [7:0] ID = 8'hA5;
   localparam int         SS = 2;

   logic         clk27m = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   rx_data = 8'h00;
   logic         data_valid = 1'b0;
   logic         cs = 1'b1;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic [127:0] regs;
   logic         wr_stb;
   logic [3:0]   wr_addr;
   logic         frame_err;

   always #18 clk27m = ~clk27m;

   spi_reg_bank #(.ID_VALUE(ID), .SYNC_STAGES(SS)) dut (
      .clk27m     (clk27m),
      .rst        (rst),
      .rx_data    (rx_data),
      .data_valid (data_valid),
      .cs         (cs),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .regs       (regs),
      .wr_stb     (wr_stb),
      .wr_addr    (wr_addr),
      .frame_err  (frame_err)
   );

   int checks = 0;
   int passed = 0;

   task automatic check_i(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: the only writer of the observed-event records.
   logic [7:0]  act_tx [$];
   logic [11:0] act_wr [$];
   int          act_err = 0;
   int          overlap = 0;

   always @(negedge clk27m) begin
      if (!rst) begin
         if (tx_start) act_tx.push_back(tx_data);
         if (wr_stb) act_wr.push_back({wr_addr, regs[{wr_addr, 3'b000} +: 8]});
         if (frame_err) act_err++;
         if (tx_start && wr_stb) overlap++;
      end
   end

   // Frame-level reference model.
   logic [7:0]  m_regs [16];
   logic [7:0]  exp_tx [$];
   logic [11:0] exp_wr [$];
   int          exp_err = 0;
   int          tx_chk = 0;
   int          wr_chk = 0;

   task automatic model_reset();
      for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
      m_regs[0] = ID;
   endtask

   function automatic logic [127:0] model_flat();
      logic [127:0] f;
      for (int k = 0; k < 16; k++) f[8*k +: 8] = m_regs[k];
      return f;
   endfunction

   task automatic model_frame(input logic [7:0] b [8], input int n);
      logic [7:0] cmd;
      int a;
      int ad;
      if (n == 0) return;
      cmd = b[0];
      if (cmd[6:4] != 3'b000) begin
         exp_err++;
      end else begin
         a = int'(cmd[3:0]);
         if (cmd[7]) begin
            for (int i = 0; i < n; i++) exp_tx.push_back(m_regs[(a + i) % 16]);
         end else begin
            for (int i = 1; i < n; i++) begin
               ad = (a + i - 1) % 16;
               if (ad != 0) begin
                  m_regs[ad] = b[i];
                  exp_wr.push_back({4'(ad), b[i]});
               end
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check_i({tag, " tx_count"}, act_tx.size(), exp_tx.size());
      for (int i = tx_chk; i < exp_tx.size() && i < act_tx.size(); i++)
         check_v({tag, " tx_data"}, 128'(act_tx[i]), 128'(exp_tx[i]));
      tx_chk = exp_tx.size();
      check_i({tag, " wr_count"}, act_wr.size(), exp_wr.size());
      for (int i = wr_chk; i < exp_wr.size() && i < act_wr.size(); i++)
         check_v({tag, " wr_addr_data"}, 128'(act_wr[i]), 128'(exp_wr[i]));
      wr_chk = exp_wr.size();
      check_i({tag, " frame_err_count"}, act_err, exp_err);
      check_v({tag, " regs"}, regs, model_flat());
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_cs_rise);
      @(negedge clk27m);
      rx_data    = b;
      data_valid = 1'b1;
      if (with_cs_rise) cs = 1'b1;
      repeat ($urandom_range(4, 6)) @(negedge clk27m);
      data_valid = 1'b0;
      repeat ($urandom_range(4, 6)) @(negedge clk27m);
   endtask

   task automatic send_frame(input logic [7:0] b [8], input int n, input bit together);
      @(negedge clk27m);
      cs = 1'b0;
      repeat (3) @(negedge clk27m);
      for (int i = 0; i < n; i++) send_byte(b[i], together && (i == n - 1));
      if (!(together && n > 0)) begin
         @(negedge clk27m);
         cs = 1'b1;
      end
      repeat (8) @(negedge clk27m);
      model_frame(b, n);
   endtask

   typedef struct {
      int         n;
      logic [7:0] b [8];
      int         chk_addr;
      logic [7:0] chk_val;
      int         n_wr;
      int         n_tx;
      int         n_err;
      bit         together;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int ca,
                               input logic [7:0] cv, input int nw, input int nt,
                               input int ne, input bit tog);
      vec_t v;
      for (int i = 0; i < 8; i++) v.b[i] = 8'h00;
      v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.chk_addr = ca; v.chk_val = cv;
      v.n_wr = nw; v.n_tx = nt; v.n_err = ne; v.together = tog;
      return v;
   endfunction

   vec_t tbl [10];

   initial begin
      int w0, t0, e0, lat;
      bit found;
      logic [7:0] rb [8];
      logic [127:0] rst_flat;

      tbl[0] = mk(3, 8'h03, 8'h5A, 8'h6B, 8'h00,  4, 8'h6B, 2, 0, 0, 1'b0);
      tbl[1] = mk(3, 8'h83, 8'h00, 8'h00, 8'h00,  3, 8'h5A, 0, 3, 0, 1'b0);
      tbl[2] = mk(3, 8'h0F, 8'h11, 8'h22, 8'h00, 15, 8'h11, 1, 0, 0, 1'b0);
      tbl[3] = mk(2, 8'h10, 8'h77, 8'h00, 8'h00,  0, 8'hA5, 0, 0, 1, 1'b0);
      tbl[4] = mk(2, 8'h80, 8'h00, 8'h00, 8'h00,  1, 8'h00, 0, 2, 0, 1'b0);
      tbl[5] = mk(2, 8'h8F, 8'h00, 8'h00, 8'h00, 15, 8'h11, 0, 2, 0, 1'b0);
      tbl[6] = mk(2, 8'h02, 8'h33, 8'h00, 8'h00,  2, 8'h33, 1, 0, 0, 1'b1);
      tbl[7] = mk(3, 8'h81, 8'h00, 8'h00, 8'h00,  3, 8'h5A, 0, 3, 0, 1'b0);
      tbl[8] = mk(4, 8'h01, 8'hC1, 8'hC2, 8'hC3,  3, 8'hC3, 3, 0, 0, 1'b0);
      tbl[9] = mk(1, 8'h05, 8'h00, 8'h00, 8'h00,  5, 8'h00, 0, 0, 0, 1'b0);

      rst_flat = '0;
      rst_flat[7:0] = ID;
      model_reset();

      // Reset state
      repeat (4) @(negedge clk27m);
      check_v("rst regs", regs, rst_flat);
      check_v("rst tx_data", 128'(tx_data), 128'(8'h00));
      check_i("rst tx_start", int'(tx_start), 0);
      check_i("rst wr_stb", int'(wr_stb), 0);
      check_v("rst wr_addr", 128'(wr_addr), 128'(4'h0));
      check_i("rst frame_err", int'(frame_err), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk27m);

      // Directed frame table
      for (int v = 0; v < 10; v++) begin
         w0 = act_wr.size(); t0 = act_tx.size(); e0 = act_err;
         send_frame(tbl[v].b, tbl[v].n, tbl[v].together);
         check_i($sformatf("vec%0d wr_pulses", v), act_wr.size() - w0, tbl[v].n_wr);
         check_i($sformatf("vec%0d tx_pulses", v), act_tx.size() - t0, tbl[v].n_tx);
         check_i($sformatf("vec%0d err_pulses", v), act_err - e0, tbl[v].n_err);
         check_v($sformatf("vec%0d reg%0d", v, tbl[v].chk_addr),
                 128'(regs[8*tbl[v].chk_addr +: 8]), 128'(tbl[v].chk_val));
         compare_all($sformatf("vec%0d", v));
      end

      // Byte latency: wr_stb visible SS+2 edges after the edge sampling data_valid high
      @(negedge clk27m);
      cs = 1'b0;
      repeat (3) @(negedge clk27m);
      send_byte(8'h01, 1'b0);
      @(negedge clk27m);
      rx_data = 8'h44;
      data_valid = 1'b1;
      @(posedge clk27m);
      lat = -1;
      found = 1'b0;
      for (int k = 1; k <= 10 && !found; k++) begin
         @(posedge clk27m);
         #1;
         if (wr_stb) begin
            found = 1'b1;
            lat = k;
         end
      end
      check_i("write latency", lat, SS + 2);
      @(negedge clk27m);
      data_valid = 1'b0;
      repeat (5) @(negedge clk27m);
      cs = 1'b1;
      repeat (8) @(negedge clk27m);
      for (int i = 0; i < 8; i++) rb[i] = 8'h00;
      rb[0] = 8'h01; rb[1] = 8'h44;
      model_frame(rb, 2);
      compare_all("latency");

      // Reset mid-write, cs held low, next byte is a command
      @(negedge clk27m);
      cs = 1'b0;
      repeat (3) @(negedge clk27m);
      send_byte(8'h02, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk27m);
      check_v("midrst regs", regs, rst_flat);
      check_v("midrst tx_data", 128'(tx_data), 128'(8'h00));
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk27m);
      t0 = act_tx.size();
      send_byte(8'h81, 1'b0);
      check_i("midrst tx_pulses", act_tx.size() - t0, 1);
      @(negedge clk27m);
      cs = 1'b1;
      repeat (8) @(negedge clk27m);
      rb[0] = 8'h81;
      model_frame(rb, 1);
      compare_all("midrst");

      // Random frames
      for (int f = 0; f < 30; f++) begin
         int n;
         bit tog;
         n = $urandom_range(1, 5);
         for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
         rb[0][6:4] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         tog = ($urandom_range(0, 3) == 0);
         send_frame(rb, n, tog);
         compare_all($sformatf("rand%0d", f));
      end

      check_i("tx_start/wr_stb overlap", overlap, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
